// File: rtl/spectrum_pkg.sv
// Shared types and constants for the spectrum bar smoother.
package spectrum_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SCAN   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int WIDTH_DEF    = 12;
  localparam int HEIGHT_W_DEF = 5;
  // Tallest bar: MSB at bit WIDTH+1 plus the half-octave bit.
  localparam int HMAX         = 2 * (WIDTH_DEF + 1) + 2;

  typedef logic [HEIGHT_W_DEF-1:0] height_t;

endpackage

// File: rtl/spectrum_bar_smoother_mag_to_height.sv
// Half-octave log height: 2*msb_index + 1, plus one when the bit below the MSB is set.
module mag_to_height #(
  parameter int MW = 14,
  parameter int HW = 5
) (
  input  logic [MW-1:0] mag,
  output logic [HW-1:0] height
);

  int unsigned p;
  logic        half;

  always_comb begin
    p    = 0;
    half = 1'b0;
    // Ascending scan so the highest set bit wins.
    for (int i = 1; i < MW; i++) begin
      if (mag[i]) begin
        p    = i;
        half = mag[i-1];
      end
    end
    if (mag == '0) begin
      height = '0;
    end else begin
      height = HW'(2 * p + 1 + 32'(half));
    end
  end

endmodule

// File: rtl/spectrum_bar_smoother.sv
// Serial per-frame scan folding N bins into BARS bars with attack/decay smoothing and peak hold.
module spectrum_bar_smoother
  import spectrum_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int N           = 256,
  parameter int BARS        = 32,
  parameter int HEIGHT_W    = HEIGHT_W_DEF,
  parameter int DECAY       = 1,
  parameter int HOLD_FRAMES = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               frame_valid,
  input  logic [0:N-1][WIDTH+1:0]            magnitude,
  output logic                               busy,
  output logic                               done,
  output logic                               frame_drop,
  output logic [0:BARS-1][HEIGHT_W-1:0]      bar_height,
  output logic [0:BARS-1][HEIGHT_W-1:0]      peak_height,
  output state_t                             fsm_state
);

  localparam int MW     = WIDTH + 2;
  localparam int G      = N / BARS;
  localparam int BIN_W  = $clog2(N);
  localparam int GRP_W  = (BARS > 1) ? $clog2(BARS) : 1;
  localparam int OFF_W  = $clog2(G);
  localparam int HOLD_W = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

  localparam logic [BIN_W-1:0]    G_MASK    = BIN_W'(G - 1);
  localparam logic [BIN_W-1:0]    LAST_BIN  = BIN_W'(N - 1);
  localparam logic [GRP_W-1:0]    LAST_GRP  = GRP_W'(BARS - 1);
  localparam logic [HEIGHT_W-1:0] DECAY_H   = HEIGHT_W'(DECAY);
  localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_FRAMES);

  state_t                        state_q, state_d;
  logic [BIN_W-1:0]              bin_q;
  logic [MW-1:0]                 grp_max_q, cur_mag, cur_max, conv_in;
  logic [HEIGHT_W-1:0]           h_new, old_bar, old_peak, decayed, peak_dec;
  logic [HEIGHT_W-1:0]           bar_nxt, peak_nxt;
  logic [HOLD_W-1:0]             old_hold, hold_nxt;
  logic [GRP_W-1:0]              upd_idx;
  logic                          in_scan, in_commit, grp_first, grp_last, upd_en;
  logic [0:BARS-1][HEIGHT_W-1:0] bar_q, peak_q;
  logic [HOLD_W-1:0]             hold_q [BARS];

  // Handshake: frame_valid is taken in IDLE or in the COMMIT (done) cycle; in SCAN it is
  // dropped and flagged on frame_drop in the same cycle. magnitude must stay stable until done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_valid) state_d = SCAN;
      SCAN:    if (bin_q == LAST_BIN) state_d = COMMIT;
      COMMIT:  state_d = frame_valid ? SCAN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign in_scan    = (state_q == SCAN);
  assign in_commit  = (state_q == COMMIT);
  assign busy       = (state_q != IDLE);
  assign done       = in_commit;
  assign frame_drop = frame_valid && in_scan;
  assign fsm_state  = state_q;

  // Counter wraps to zero after the last bin because N is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       bin_q <= '0;
    else if (in_scan) bin_q <= bin_q + 1'b1;
    else              bin_q <= '0;
  end

  assign cur_mag   = magnitude[bin_q];
  assign grp_first = (bin_q & G_MASK) == '0;
  assign grp_last  = (bin_q & G_MASK) == G_MASK;
  assign cur_max   = (grp_first || cur_mag > grp_max_q) ? cur_mag : grp_max_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       grp_max_q <= '0;
    else if (in_scan) grp_max_q <= cur_max;
  end

  // The last group is finished from the group-max register during COMMIT.
  assign conv_in = in_commit ? grp_max_q : cur_max;
  assign upd_idx = in_commit ? LAST_GRP : GRP_W'(bin_q >> OFF_W);
  assign upd_en  = in_commit || (in_scan && grp_last && upd_idx != LAST_GRP);

  mag_to_height #(
    .MW (MW),
    .HW (HEIGHT_W)
  ) u_mag_to_height (
    .mag    (conv_in),
    .height (h_new)
  );

  assign old_bar  = bar_q[upd_idx];
  assign old_peak = peak_q[upd_idx];
  assign old_hold = hold_q[upd_idx];

  always_comb begin
    decayed  = (old_bar > DECAY_H) ? old_bar - DECAY_H : '0;
    bar_nxt  = (h_new > decayed) ? h_new : decayed;
    peak_dec = (old_peak != '0) ? old_peak - 1'b1 : '0;
    peak_nxt = old_peak;
    hold_nxt = old_hold;
    if (h_new >= old_peak) begin
      peak_nxt = h_new;
      hold_nxt = HOLD_INIT;
    end else if (old_hold != '0) begin
      hold_nxt = old_hold - 1'b1;
    end else begin
      peak_nxt = (bar_nxt > peak_dec) ? bar_nxt : peak_dec;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_q  <= '0;
      peak_q <= '0;
      for (int b = 0; b < BARS; b++) hold_q[b] <= '0;
    end else if (upd_en) begin
      bar_q[upd_idx]  <= bar_nxt;
      peak_q[upd_idx] <= peak_nxt;
      hold_q[upd_idx] <= hold_nxt;
    end
  end

  assign bar_height  = bar_q;
  assign peak_height = peak_q;

endmodule

// File: tb/tb_spectrum_bar_smoother.sv
// Directed and randomized frames checked against a frame-level reference model.
module tb_spectrum_bar_smoother;
  import spectrum_pkg::*;

  localparam int WIDTH       = 12;
  localparam int N           = 256;
  localparam int BARS        = 32;
  localparam int HEIGHT_W    = 5;
  localparam int DECAY       = 1;
  localparam int HOLD_FRAMES = 8;
  localparam int MW          = WIDTH + 2;
  localparam int G           = N / BARS;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic                          frame_valid = 1'b0;
  logic [0:N-1][MW-1:0]          magnitude = '0;
  logic                          busy, done, frame_drop;
  logic [0:BARS-1][HEIGHT_W-1:0] bar_height, peak_height;
  state_t                        fsm_state;

  spectrum_bar_smoother dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_valid (frame_valid),
    .magnitude   (magnitude),
    .busy        (busy),
    .done        (done),
    .frame_drop  (frame_drop),
    .bar_height  (bar_height),
    .peak_height (peak_height),
    .fsm_state   (fsm_state)
  );

  // scoreboard
  int total = 0;
  int bad   = 0;
  logic [HEIGHT_W-1:0] exp_q[$];
  logic [HEIGHT_W-1:0] exp_peak_q[$];
  logic [MW-1:0]       mag_mem [N];
  int ref_bar  [BARS];
  int ref_peak [BARS];
  int ref_hold [BARS];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int height_of(input int m);
    int p;
    if (m == 0) return 0;
    p = $clog2(m + 1) - 1;
    return 2 * p + 1 + ((p > 0) ? ((m >> (p - 1)) & 1) : 0);
  endfunction

  task automatic model_reset();
    for (int b = 0; b < BARS; b++) begin
      ref_bar[b] = 0; ref_peak[b] = 0; ref_hold[b] = 0;
    end
    exp_q.delete();
    exp_peak_q.delete();
  endtask

  task automatic model_frame();
    int m, h, fall;
    for (int b = 0; b < BARS; b++) begin
      m = 0;
      for (int k = 0; k < G; k++) if (int'(mag_mem[b*G+k]) > m) m = int'(mag_mem[b*G+k]);
      h = height_of(m);
      fall = (ref_bar[b] > DECAY) ? ref_bar[b] - DECAY : 0;
      ref_bar[b] = (h >= ref_bar[b]) ? h : ((h > fall) ? h : fall);
      if (h >= ref_peak[b]) begin
        ref_peak[b] = h;
        ref_hold[b] = HOLD_FRAMES;
      end else if (ref_hold[b] > 0) begin
        ref_hold[b]--;
      end else begin
        ref_peak[b] = (ref_bar[b] > ref_peak[b] - 1) ? ref_bar[b] : ref_peak[b] - 1;
      end
      exp_q.push_back(HEIGHT_W'(ref_bar[b]));
      exp_peak_q.push_back(HEIGHT_W'(ref_peak[b]));
    end
  endtask

  // drivers
  task automatic load(input bit rnd);
    for (int i = 0; i < N; i++) begin
      mag_mem[i] = rnd ? MW'($urandom_range(0, (1 << MW) - 1) >> $urandom_range(0, MW)) : '0;
      magnitude[i] = mag_mem[i];
    end
  endtask

  task automatic set_bin(input int idx, input int val);
    mag_mem[idx] = MW'(val);
    magnitude[idx] = mag_mem[idx];
  endtask

  task automatic compare_bars(input string tag);
    logic [HEIGHT_W-1:0] e, ep;
    check({tag, "_qsize"}, exp_q.size(), BARS);
    for (int b = 0; b < BARS; b++) begin
      e  = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      ep = (exp_peak_q.size() > 0) ? exp_peak_q.pop_front() : '0;
      check($sformatf("%s_bar%0d", tag, b), bar_height[b], e);
      check($sformatf("%s_peak%0d", tag, b), peak_height[b], ep);
      check($sformatf("%s_peak_ge_bar%0d", tag, b), peak_height[b] >= bar_height[b], 1);
    end
  endtask

  // Caller raises frame_valid at a negedge; this walks cycles 1.. until done.
  task automatic run_scan(input int drop_at, input bit chain, input bit check_first,
                          output int lat, output int busy_n, output int drop_n);
    lat = 0; busy_n = 0; drop_n = 0;
    for (int cyc = 1; cyc <= N + 20; cyc++) begin
      @(negedge clk);
      frame_valid = (cyc == drop_at);
      #1;
      if (cyc == 1 && check_first) compare_bars("prev_frame");
      if (busy) busy_n++;
      if (frame_drop) drop_n++;
      if (done) begin
        lat = cyc;
        if (chain) frame_valid = 1'b1;
        break;
      end
    end
  endtask

  task automatic frame(input string tag, input int drop_at, input int exp_drops);
    int lat, busy_n, drop_n;
    @(negedge clk);
    frame_valid = 1'b1;
    run_scan(drop_at, 1'b0, 1'b0, lat, busy_n, drop_n);
    check({tag, "_latency"}, lat, N + 1);
    check({tag, "_busy_cycles"}, busy_n, N + 1);
    check({tag, "_drops"}, drop_n, exp_drops);
    model_frame();
    @(negedge clk);
    #1;
    compare_bars(tag);
  endtask

  initial begin
    int lat, busy_n, drop_n, dones;
    model_reset();
    load(1'b0);

    // reset state
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_drop", frame_drop, 0);
    check("rst_state", fsm_state, IDLE);
    check("rst_bars_zero", (bar_height == '0) && (peak_height == '0), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    frame("zero", 0, 0);

    load(1'b0);
    set_bin(0, 1);
    set_bin(9, 'h40);
    frame("two_bins", 0, 0);
    check("dir_bar0", bar_height[0], 1);
    check("dir_bar1", bar_height[1], 13);
    check("dir_bar2", bar_height[2], 0);
    check("dir_peak1", peak_height[1], 13);

    load(1'b0);
    set_bin(255, 'h3FFF);
    frame("full_scale", 0, 0);
    check("dir_bar31_max", bar_height[31], 28);

    load(1'b0);
    for (int k = 1; k <= 10; k++) begin
      frame("decay", 0, 0);
      check($sformatf("decay_bar31_f%0d", k), bar_height[31], 28 - k);
      check($sformatf("hold_peak31_f%0d", k), peak_height[31], (k <= HOLD_FRAMES) ? 28 : 36 - k);
    end

    load(1'b1);
    frame("drop", 10, 1);

    // reset in the middle of a scan
    load(1'b1);
    @(negedge clk);
    frame_valid = 1'b1;
    @(negedge clk);
    frame_valid = 1'b0;
    repeat (19) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_bars_zero", (bar_height == '0) && (peak_height == '0), 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_state", fsm_state, IDLE);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < N + 10; c++) begin
      @(negedge clk);
      #1;
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    check("midrst_bars_still_zero", bar_height == '0, 1);

    load(1'b1);
    frame("after_reset", 0, 0);

    // back-to-back frames, each started in the previous done cycle
    load(1'b1);
    @(negedge clk);
    frame_valid = 1'b1;
    for (int f = 0; f < 20; f++) begin
      run_scan(0, f < 19, f > 0, lat, busy_n, drop_n);
      check($sformatf("b2b_latency_f%0d", f), lat, N + 1);
      check($sformatf("b2b_busy_f%0d", f), busy_n, N + 1);
      check($sformatf("b2b_drops_f%0d", f), drop_n, 0);
      model_frame();
      if (f < 19) load(1'b1);
    end
    @(negedge clk);
    #1;
    compare_bars("b2b_last");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
